ale_job_loader: RTL and testbench
=================================

Name: ale_job_loader

Overview:
- Sits directly upstream of the Alephium miner core and turns a host byte stream (8-bit valid/ready, with last) into the core's job-load sequence.
- Sequence: a one-cycle update trigger, then a burst of little-endian packed 32-bit data writes.
- Checks the byte count against the chunk length minus the header bytes that the core supplies itself (nonce and groups).
- Reports completion and length errors.

Parameters:
- HDR_BYTES, 28: bytes of the chunk not streamed; payload length is ChunkLength_I - HDR_BYTES.
- MAX_PAYLOAD, 1024: largest accepted payload in bytes; a longer job is an error.

Ports:
- Clk input 1: clock.
- Rst input 1: reset, asynchronous, active-high.
- Start_I input 1: single-cycle job start request.
- ChunkLength_I input 32: chunk length in bytes; sampled on an accepted Start_I.
- S_Data_I input 8: stream byte.
- S_Valid_I input 1: stream byte valid.
- S_Last_I input 1: marks the final byte of the job.
- S_Ready_O output 1: loader accepts a byte when S_Valid_I and S_Ready_O are both high.
- UpdateTrigger_O output 1: one-cycle pulse to the miner core.
- Wr_O output 1: one-cycle data-write strobe to the core.
- Data_O output 32: packed word; valid only while Wr_O is high.
- Busy_O output 1: high from the accepted start until Done_O or an error.
- Done_O output 1: one-cycle pulse after the final word is written.
- Err_O output 1: sticky error flag; cleared by the next accepted Start_I.
- WordCount_O output 16: words written in the current or last job.

Behaviour:
- Reset: state IDLE. S_Ready_O, UpdateTrigger_O, Wr_O, Busy_O, Done_O and Err_O are all 0. Data_O, WordCount_O, the byte counter and the pack register are all 0. Reset asserted mid-job aborts immediately and emits no further Wr_O.
- States are IDLE, TRIG, LOAD, FLUSH.
- IDLE, with Start_I=1:
  - Compute P = ChunkLength_I - HDR_BYTES, using an unsigned 32-bit compare before the subtract.
  - If ChunkLength_I <= HDR_BYTES or P > MAX_PAYLOAD: set Err_O=1, stay IDLE, Busy_O stays 0.
  - Otherwise: latch P, clear Err_O, WordCount_O, the byte counter and the pack register, set Busy_O=1, go to TRIG.
- Start_I in any state other than IDLE is ignored.
- TRIG: UpdateTrigger_O=1 for exactly this one cycle; S_Ready_O=0. Next state is LOAD, so the first Wr_O is at least one cycle after the trigger cycle.
- LOAD: S_Ready_O=1. On each accepted byte:
  - The byte goes into pack lane (bytecount mod 4), so the first byte lands in Data_O[7:0] and the fourth in [31:24]; bytecount is then incremented.
  - When lane 3 is filled, the registered output on the next cycle is Wr_O=1 with the full word, and WordCount_O increments in the same cycle as Wr_O.
  - The pack register lanes are cleared after each emitted word.
  - Rate is at most one byte per cycle, so a word can be emitted every 4th cycle at most. The core gives no backpressure.
- End of job: an accepted byte with S_Last_I=1 and new bytecount == P goes to FLUSH.
  - If bytecount mod 4 != 0, FLUSH emits the partial word with the unfilled upper lanes set to zero (Wr_O=1 one cycle later).
  - If the last byte completed a word, only that word is written, with no extra zero word.
  - Done_O pulses on the cycle after the last Wr_O, Busy_O drops in that same cycle, and the state returns to IDLE.
- Length errors (S_Ready_O=0 from the next cycle; Err_O=1, Busy_O=0, back to IDLE, no Done_O):
  - S_Last_I=1 on an accepted byte with bytecount+1 < P: early last. The partial word in the pack register is discarded.
  - An accepted byte with bytecount+1 == P and S_Last_I=0: missing last. Words completed before the error have already been written; the partial word is not.
- FLUSH: S_Ready_O=0.
- Timing: S_Ready_O is a registered output. The last accepted byte deasserts it on the following cycle, so no byte beyond the job is accepted.
- S_Valid_I outside LOAD is not consumed.
- Widths: bytecount is 16 bits, which covers MAX_PAYLOAD up to 65535. WordCount_O = ceil(P/4) on a clean job.

Test Plan:
- ChunkLength_I=288, 260 bytes 0x18,0x19,... with last on byte 260 -> one UpdateTrigger_O; 65 Wr_O; first Data_O=0x1B1A1918; Done_O one cycle after the 65th write; WordCount_O=65; Err_O=0.
- ChunkLength_I=35, bytes 0x01..0x07 with last on byte 7 -> Wr_O words 0x04030201 then 0x00070605; Done_O; WordCount_O=2.
- ChunkLength_I=36, S_Last_I on byte 5 of 8 -> exactly 1 Wr_O (0x04030201); Err_O=1; no Done_O; S_Ready_O=0.
- ChunkLength_I=20, then ChunkLength_I=28+MAX_PAYLOAD+1 -> Err_O=1 with no trigger for either; next valid Start_I clears Err_O.
- Rst pulsed after 10 words of a 288-byte job -> all outputs 0 asynchronously; no Wr_O afterwards; a fresh job then completes normally.
- Start_I re-asserted during LOAD -> ignored, with no second trigger; the job completes with the original length.

Source files
------------

// File: rtl/ale_job_loader.sv
`default_nettype none
// ============================================================================
// Module   : ale_job_loader
// Brief    : Converts a host byte stream into the miner core's job-load
//            sequence (update trigger, then packed 32-bit data writes).
// Revision : 1.0
// ============================================================================
module ale_job_loader #(
    parameter int HDR_BYTES   = 28,
    parameter int MAX_PAYLOAD = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start_I,
    input  logic [31:0] ChunkLength_I,
    input  logic [7:0]  S_Data_I,
    input  logic        S_Valid_I,
    input  logic        S_Last_I,
    output logic        S_Ready_O,
    output logic        UpdateTrigger_O,
    output logic        Wr_O,
    output logic [31:0] Data_O,
    output logic        Busy_O,
    output logic        Done_O,
    output logic        Err_O,
    output logic [15:0] WordCount_O
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIG  = 2'd1,
        LOAD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_ready;
    logic        r_trig;
    logic        r_wr;
    logic [31:0] r_data;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_word_cnt;
    logic [15:0] r_byte_cnt;
    logic [15:0] r_payload;
    logic [31:0] r_pack;

    logic [31:0] w_payload;
    logic        w_len_bad;
    logic        w_accept;
    logic [1:0]  w_lane;
    logic [15:0] w_cnt_next;
    logic [31:0] w_pack_next;

    // Compare first so a short chunk never wraps into a huge payload.
    assign w_payload  = ChunkLength_I - 32'(HDR_BYTES);
    assign w_len_bad  = (ChunkLength_I <= 32'(HDR_BYTES)) ||
                        (w_payload > 32'(MAX_PAYLOAD));
    assign w_accept   = (r_state == LOAD) && r_ready && S_Valid_I;
    assign w_lane     = r_byte_cnt[1:0];
    assign w_cnt_next = r_byte_cnt + 16'd1;
    // Lanes are zeroed after every emitted word, so OR-ing in the byte suffices.
    assign w_pack_next = r_pack | ({24'd0, S_Data_I} << {w_lane, 3'b000});

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_ready    <= 1'b0;
            r_trig     <= 1'b0;
            r_wr       <= 1'b0;
            r_data     <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_word_cnt <= 16'd0;
            r_byte_cnt <= 16'd0;
            r_payload  <= 16'd0;
            r_pack     <= 32'd0;
        end else begin
            r_trig <= 1'b0;
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start_I) begin
                        if (w_len_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_payload  <= w_payload[15:0];
                            r_err      <= 1'b0;
                            r_word_cnt <= 16'd0;
                            r_byte_cnt <= 16'd0;
                            r_pack     <= 32'd0;
                            r_busy     <= 1'b1;
                            r_trig     <= 1'b1;
                            r_state    <= TRIG;
                        end
                    end
                end
                TRIG: begin
                    r_ready <= 1'b1;
                    r_state <= LOAD;
                end
                LOAD: begin
                    if (w_accept) begin
                        r_byte_cnt <= w_cnt_next;
                        if (w_cnt_next == r_payload && S_Last_I) begin
                            // Final byte: emit whatever is packed, upper lanes already zero.
                            r_wr       <= 1'b1;
                            r_data     <= w_pack_next;
                            r_word_cnt <= r_word_cnt + 16'd1;
                            r_pack     <= 32'd0;
                            r_ready    <= 1'b0;
                            r_state    <= FLUSH;
                        end else if (w_cnt_next == r_payload || S_Last_I) begin
                            // Missing or early last: drop the partial word.
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b0;
                            r_pack  <= 32'd0;
                            r_state <= IDLE;
                        end else if (w_lane == 2'd3) begin
                            r_wr       <= 1'b1;
                            r_data     <= w_pack_next;
                            r_word_cnt <= r_word_cnt + 16'd1;
                            r_pack     <= 32'd0;
                        end else begin
                            r_pack <= w_pack_next;
                        end
                    end
                end
                FLUSH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign S_Ready_O       = r_ready;
    assign UpdateTrigger_O = r_trig;
    assign Wr_O            = r_wr;
    assign Data_O          = r_data;
    assign Busy_O          = r_busy;
    assign Done_O          = r_done;
    assign Err_O           = r_err;
    assign WordCount_O     = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ale_job_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ale_job_loader
// Brief    : Scoreboard bench for ale_job_loader.
// Revision : 1.0
// ============================================================================
module tb_ale_job_loader;

    logic        Clk;
    logic        Rst;
    logic        Start_I;
    logic [31:0] ChunkLength_I;
    logic [7:0]  S_Data_I;
    logic        S_Valid_I;
    logic        S_Last_I;
    logic        S_Ready_O;
    logic        UpdateTrigger_O;
    logic        Wr_O;
    logic [31:0] Data_O;
    logic        Busy_O;
    logic        Done_O;
    logic        Err_O;
    logic [15:0] WordCount_O;

    ale_job_loader #(.HDR_BYTES(28), .MAX_PAYLOAD(1024)) u_dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Start_I         (Start_I),
        .ChunkLength_I   (ChunkLength_I),
        .S_Data_I        (S_Data_I),
        .S_Valid_I       (S_Valid_I),
        .S_Last_I        (S_Last_I),
        .S_Ready_O       (S_Ready_O),
        .UpdateTrigger_O (UpdateTrigger_O),
        .Wr_O            (Wr_O),
        .Data_O          (Data_O),
        .Busy_O          (Busy_O),
        .Done_O          (Done_O),
        .Err_O           (Err_O),
        .WordCount_O     (WordCount_O)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_trig   = 0;
    int          n_wr     = 0;
    int          n_done   = 0;
    int          cyc      = 0;
    int          last_wr_cyc = 0;
    logic [15:0] prev_wc  = 16'd0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Output monitor: pops the scoreboard on every write strobe.
    always @(negedge Clk) begin
        cyc++;
        if (UpdateTrigger_O) n_trig++;
        if (Wr_O) begin
            n_wr++;
            last_wr_cyc = cyc;
            check_eq("wc_step", {16'd0, WordCount_O}, {16'd0, prev_wc + 16'd1});
            if (exp_q.size() == 0) check_eq("unexpected_wr", Data_O, 32'hDEAD_BEEF);
            else check_eq("data", Data_O, exp_q.pop_front());
        end
        if (Done_O) begin
            n_done++;
            check_eq("done_lat", cyc - last_wr_cyc, 1);
        end
        prev_wc = WordCount_O;
    end

    task automatic pulse_start(input int clen);
        @(posedge Clk); #1;
        Start_I = 1'b1; ChunkLength_I = clen;
        @(posedge Clk); #1;
        Start_I = 1'b0;
    endtask

    task automatic bad_start(input int clen);
        int t0;
        t0 = n_trig;
        pulse_start(clen);
        repeat (3) @(negedge Clk);
        check_eq("bad_err", Err_O, 1);
        check_eq("bad_busy", Busy_O, 0);
        check_eq("bad_trig", n_trig - t0, 0);
    endtask

    task automatic run_job(input int clen, input int nbytes, input int last_at,
                           input int restart_at, input int abort_at, input logic [7:0] base);
        int p, t0, w0, d0, npushed, tmo, nw;
        logic acc;
        logic [31:0] w;
        bit exp_err;
        p = clen - 28; t0 = n_trig; w0 = n_wr; d0 = n_done;
        npushed = 0; w = 0;
        exp_err = (last_at != p);
        pulse_start(clen);
        for (int i = 1; i <= nbytes; i++) begin
            S_Valid_I = 1'b1;
            S_Data_I  = base + 8'(i - 1);
            S_Last_I  = (i == last_at);
            if (i == restart_at) begin
                Start_I = 1'b1; ChunkLength_I = 40;
            end
            acc = 1'b0; tmo = 0;
            while (!acc && tmo < 50) begin
                @(negedge Clk); acc = S_Ready_O;
                @(posedge Clk); #1;
                Start_I = 1'b0;
                tmo++;
            end
            if (!acc) begin
                check_eq("accept_tmo", 0, 1);
                break;
            end
            w = w | ({24'd0, S_Data_I} << (8 * ((i - 1) % 4)));
            if ((i % 4 == 0 && i < p && i != last_at) || (i == p && i == last_at)) begin
                exp_q.push_back(w); npushed++; w = 0;
            end
            if (i == last_at) break;
            if (i == abort_at) begin
                S_Valid_I = 1'b0;
                repeat (2) @(posedge Clk);
                #3 Rst = 1'b1;
                #1;
                check_eq("abort_outs", {26'd0, S_Ready_O, UpdateTrigger_O, Wr_O, Busy_O, Done_O, Err_O}, 0);
                check_eq("abort_data", Data_O, 0);
                check_eq("abort_wc", {16'd0, WordCount_O}, 0);
                check_eq("abort_q", exp_q.size(), 0);
                nw = n_wr;
                @(posedge Clk); #1 Rst = 1'b0;
                repeat (20) @(posedge Clk);
                check_eq("abort_no_wr", n_wr - nw, 0);
                check_eq("abort_trig", n_trig - t0, 1);
                return;
            end
        end
        S_Valid_I = 1'b0; S_Last_I = 1'b0;
        tmo = 0;
        do begin
            @(negedge Clk); tmo++;
        end while (!(Done_O || Err_O) && tmo < 20);
        if (tmo >= 20) check_eq("end_tmo", 0, 1);
        repeat (2) @(negedge Clk);
        check_eq("trig", n_trig - t0, 1);
        check_eq("done", n_done - d0, exp_err ? 0 : 1);
        check_eq("err", Err_O, exp_err);
        check_eq("busy", Busy_O, 0);
        check_eq("ready", S_Ready_O, 0);
        check_eq("nwr", n_wr - w0, npushed);
        check_eq("wc", {16'd0, WordCount_O}, npushed);
        check_eq("q_empty", exp_q.size(), 0);
    endtask

    initial begin
        Rst = 1'b1; Start_I = 1'b0; ChunkLength_I = 0;
        S_Data_I = 0; S_Valid_I = 0; S_Last_I = 0;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("rst_outs", {26'd0, S_Ready_O, UpdateTrigger_O, Wr_O, Busy_O, Done_O, Err_O}, 0);
        check_eq("rst_data", Data_O, 0);
        check_eq("rst_wc", {16'd0, WordCount_O}, 0);
        Rst = 1'b0;
        repeat (2) @(posedge Clk);

        run_job(288, 260, 260, 0, 0, 8'h18);
        check_eq("wc65", {16'd0, WordCount_O}, 65);
        run_job(35, 7, 7, 0, 0, 8'h01);
        run_job(36, 8, 5, 0, 0, 8'h01);
        bad_start(20);
        bad_start(28 + 1024 + 1);
        bad_start(28);
        run_job(29, 1, 1, 0, 0, 8'hAA);
        run_job(288, 260, 260, 0, 40, 8'h18);
        run_job(288, 260, 260, 0, 0, 8'h18);
        run_job(48, 20, 20, 3, 0, 8'h40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
